// File: rtl/mem_bus_arbiter_if.sv
// Fetch/data request bundle and single-port memory handshake.
// master: the arbiter's view; slave: requesters and memory.
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [DATA_W-1:0] i_rdata;
   logic              i_err;

   logic              d_re;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [BE_W-1:0]   d_be;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;
   logic              d_err;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [BE_W-1:0]   mem_be;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   logic              stall;
   logic              bus_err;

   modport master (
      input  i_req, i_addr,
      input  d_re, d_we, d_addr, d_wdata, d_be,
      input  mem_ack, mem_rdata,
      output i_ack, i_rdata, i_err,
      output d_ack, d_rdata, d_err,
      output mem_req, mem_we, mem_addr,
      output mem_wdata, mem_be,
      output stall, bus_err
   );

   modport slave (
      output i_req, i_addr,
      output d_re, d_we, d_addr, d_wdata, d_be,
      output mem_ack, mem_rdata,
      input  i_ack, i_rdata, i_err,
      input  d_ack, d_rdata, d_err,
      input  mem_req, mem_we, mem_addr,
      input  mem_wdata, mem_be,
      input  stall, bus_err
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data.
// One transaction in flight; ack pulses one cycle after mem_ack or timeout.
module mem_bus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   mem_bus_arbiter_if.master bus
);
   localparam int BE_W = DATA_W / 8;
   localparam int TW =
      (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);
   localparam bit TO_EN = (TIMEOUT > 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              last_d_q, last_d_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [BE_W-1:0]   mem_be_q, mem_be_d;
   logic              i_ack_q, i_ack_d;
   logic              i_err_q, i_err_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic              d_ack_q, d_ack_d;
   logic              d_err_q, d_err_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              bus_err_q, bus_err_d;

   logic d_any;
   logic i_elig;
   logic d_elig;
   logic pick_d;
   logic done_ok;
   logic done_to;

   always_comb begin
      d_any       = bus.d_re | bus.d_we;
      // a requester is blind in its own ack cycle
      i_elig      = bus.i_req & ~i_ack_q;
      d_elig      = d_any & ~d_ack_q;
      pick_d      = d_elig & (~i_elig | ~last_d_q);
      done_ok     = 1'b0;
      done_to     = 1'b0;
      state_d     = state_q;
      last_d_d    = last_d_q;
      timer_d     = timer_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      i_ack_d     = 1'b0;
      i_err_d     = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_ack_d     = 1'b0;
      d_err_d     = 1'b0;
      d_rdata_d   = d_rdata_q;
      bus_err_d   = bus_err_q
                  | (bus.d_re & bus.d_we);

      unique case (state_q)
         IDLE: begin
            if (i_elig | d_elig) begin
               timer_d   = '0;
               mem_req_d = 1'b1;
               last_d_d  = pick_d;
               if (pick_d) begin
                  state_d     = BUSY_D;
                  mem_we_d    = bus.d_we;
                  mem_addr_d  = bus.d_addr;
                  mem_wdata_d = bus.d_wdata;
                  mem_be_d    = bus.d_we ? bus.d_be
                                         : '1;
               end else begin
                  state_d     = BUSY_I;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = bus.i_addr;
                  mem_wdata_d = '0;
                  mem_be_d    = '1;
               end
            end
         end
         BUSY_I, BUSY_D: begin
            if (bus.mem_ack) begin
               done_ok = 1'b1;
            end else if (TO_EN && timer_q == T_MAX) begin
               done_to = 1'b1;
            end else if (TO_EN) begin
               timer_d = timer_q + TW'(1);
               // withdraw the request; abort next cycle
               if (timer_d == T_MAX) begin
                  mem_req_d = 1'b0;
               end
            end
            if (done_ok | done_to) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if (state_q == BUSY_I) begin
                  i_ack_d = 1'b1;
                  i_err_d = done_to;
                  if (done_ok) begin
                     i_rdata_d = bus.mem_rdata;
                  end
               end else begin
                  d_ack_d = 1'b1;
                  d_err_d = done_to;
                  if (done_ok && !mem_we_q) begin
                     d_rdata_d = bus.mem_rdata;
                  end
               end
            end
            if (done_to) begin
               bus_err_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         last_d_q    <= 1'b0;
         timer_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         i_ack_q     <= 1'b0;
         i_err_q     <= 1'b0;
         i_rdata_q   <= '0;
         d_ack_q     <= 1'b0;
         d_err_q     <= 1'b0;
         d_rdata_q   <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_d_q    <= last_d_d;
         timer_q     <= timer_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         i_ack_q     <= i_ack_d;
         i_err_q     <= i_err_d;
         i_rdata_q   <= i_rdata_d;
         d_ack_q     <= d_ack_d;
         d_err_q     <= d_err_d;
         d_rdata_q   <= d_rdata_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign bus.i_ack     = i_ack_q;
   assign bus.i_err     = i_err_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.d_err     = d_err_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.bus_err   = bus_err_q;
   // forced low during reset like every other output
   assign bus.stall = rst
      & ((bus.i_req & ~i_ack_q)
       | (d_any & ~d_ack_q));
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table, directed sequences and
// randomized traffic against a cycle-arithmetic reference model.
module tb_mem_bus_arbiter;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_bus_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      bit          pre_rst;
      int          kind;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          lat;
      logic [31:0] rdata;
      int          exp_ack;
      int          exp_nreq;
      bit          exp_we;
      logic [3:0]  exp_be;
      bit          exp_err;
      logic [31:0] exp_rd;
      bit          exp_berr;
   } vec_t;

   vec_t vecs[7];

   task automatic chk_b(input string nm, input logic a, input logic e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, a, e);
      end
   endtask

   task automatic chk_w(input string nm, input logic [31:0] a,
                        input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, a, e);
      end
   endtask

   task automatic chk_be(input string nm, input logic [3:0] a,
                         input logic [3:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, a, e);
      end
   endtask

   task automatic chk_i(input string nm, input int a, input int e);
      n_cmp++;
      if (a != e) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", nm, a, e);
      end
   endtask

   task automatic idle_inputs();
      bus.i_req     = 1'b0;
      bus.i_addr    = '0;
      bus.d_re      = 1'b0;
      bus.d_we      = 1'b0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      bus.d_be      = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run_vec(input vec_t v);
      int   nreq;
      int   ack_c;
      logic ack;
      bit   on_d;
      nreq  = 0;
      ack_c = -1;
      on_d  = (v.kind != 0);
      if (v.pre_rst) do_reset();
      @(negedge clk);
      bus.i_req   = (v.kind == 0);
      bus.i_addr  = v.addr;
      bus.d_re    = (v.kind == 1 || v.kind == 3);
      bus.d_we    = (v.kind >= 2);
      bus.d_addr  = v.addr;
      bus.d_wdata = v.wdata;
      bus.d_be    = v.be;
      bus.mem_ack = 1'b0;
      #1 chk_b("v_stall_c0", bus.stall, 1'b1);
      for (int c = 1; c <= 12 && ack_c < 0; c++) begin
         @(negedge clk);
         ack = on_d ? bus.d_ack : bus.i_ack;
         if (ack) begin
            ack_c = c;
            chk_b("v_err", on_d ? bus.d_err : bus.i_err, v.exp_err);
            chk_w("v_rdata", on_d ? bus.d_rdata : bus.i_rdata,
                  v.exp_rd);
            chk_b("v_bus_err", bus.bus_err, v.exp_berr);
            chk_b("v_stall_ack", bus.stall, 1'b0);
         end else begin
            chk_b("v_stall_wait", bus.stall, 1'b1);
         end
         if (bus.mem_req) begin
            nreq++;
            chk_b("v_mem_we", bus.mem_we, v.exp_we);
            chk_w("v_mem_addr", bus.mem_addr, v.addr);
            chk_be("v_mem_be", bus.mem_be, v.exp_be);
            if (v.exp_we) chk_w("v_mem_wdata", bus.mem_wdata, v.wdata);
         end
         bus.mem_ack   = bus.mem_req && (nreq - 1 == v.lat);
         bus.mem_rdata = bus.mem_ack ? v.rdata : $urandom;
      end
      chk_i("v_ack_cycle", ack_c, v.exp_ack);
      chk_i("v_req_cycles", nreq, v.exp_nreq);
      @(negedge clk);
      idle_inputs();
      chk_b("v_no_regrant", bus.mem_req, 1'b0);
   endtask

   // reference model state for the random phase
   int          own, req_last, done_c, ack_at, lat;
   bit          last_d, tmo, ih, dh, dw;
   bit          ie, de, pk;
   logic        t_we;
   logic [31:0] t_addr, t_wdata, t_rd, ia, da, dwd;
   logic [3:0]  t_be, dbe;
   logic        e_i_ack, e_d_ack, e_i_err, e_d_err, e_req, e_berr;
   logic        n_i_ack, n_d_ack, n_i_err, n_d_err, n_req;
   logic [31:0] e_i_rd, e_d_rd;

   initial begin
      int   ntx, d_c, i_c;
      bit   prev;
      logic [31:0] a1, a2;

      vecs[0] = '{1'b0, 0, 32'h100, 32'h0, 4'h0, 0, 32'hDEADBEEF,
                  2, 1, 1'b0, 4'hF, 1'b0, 32'hDEADBEEF, 1'b0};
      vecs[1] = '{1'b0, 1, 32'h80, 32'h0, 4'h0, 2, 32'hCAFEF00D,
                  4, 3, 1'b0, 4'hF, 1'b0, 32'hCAFEF00D, 1'b0};
      vecs[2] = '{1'b0, 2, 32'h40, 32'h12345678, 4'h3, 3, 32'hBAD0BAD0,
                  5, 4, 1'b1, 4'h3, 1'b0, 32'hCAFEF00D, 1'b0};
      vecs[3] = '{1'b0, 0, 32'h104, 32'h0, 4'h0, 1, 32'h01020304,
                  3, 2, 1'b0, 4'hF, 1'b0, 32'h01020304, 1'b0};
      vecs[4] = '{1'b0, 3, 32'h44, 32'hAABBCCDD, 4'hF, 0, 32'h55555555,
                  2, 1, 1'b1, 4'hF, 1'b0, 32'hCAFEF00D, 1'b1};
      vecs[5] = '{1'b1, 1, 32'h200, 32'h0, 4'h0, -1, 32'h77777777,
                  6, 4, 1'b0, 4'hF, 1'b1, 32'h0, 1'b1};
      vecs[6] = '{1'b0, 0, 32'h300, 32'h0, 4'h0, -1, 32'h66666666,
                  6, 4, 1'b0, 4'hF, 1'b1, 32'h0, 1'b1};

      idle_inputs();
      #2 rst = 1'b0;
      #1;
      chk_b("rst_mem_req", bus.mem_req, 1'b0);
      chk_b("rst_i_ack", bus.i_ack, 1'b0);
      chk_b("rst_d_ack", bus.d_ack, 1'b0);
      chk_b("rst_stall", bus.stall, 1'b0);
      chk_b("rst_bus_err", bus.bus_err, 1'b0);
      chk_w("rst_mem_addr", bus.mem_addr, 32'h0);
      chk_be("rst_mem_be", bus.mem_be, 4'h0);
      @(negedge clk);
      rst = 1'b1;

      // simultaneous requests right after reset: D wins, then IF
      @(negedge clk);
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h500;
      bus.d_re   = 1'b1;
      bus.d_addr = 32'h600;
      ntx = 0; d_c = -1; i_c = -1; prev = 1'b0;
      a1 = '0; a2 = '0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (d_c >= 0 && c == d_c + 1) bus.d_re = 1'b0;
         if (i_c >= 0 && c == i_c + 1) bus.i_req = 1'b0;
         if (bus.d_ack) begin
            d_c = c;
            chk_w("rr_d_rdata", bus.d_rdata, 32'h5A5A0600);
         end
         if (bus.i_ack) begin
            i_c = c;
            chk_w("rr_i_rdata", bus.i_rdata, 32'h5A5A0500);
         end
         if (bus.mem_req && !prev) begin
            ntx++;
            if (ntx == 1) a1 = bus.mem_addr;
            else a2 = bus.mem_addr;
         end
         prev = bus.mem_req;
         bus.mem_ack   = bus.mem_req;
         bus.mem_rdata = bus.mem_addr ^ 32'h5A5A0000;
      end
      chk_i("rr_tx_count", ntx, 2);
      chk_w("rr_first", a1, 32'h600);
      chk_w("rr_second", a2, 32'h500);
      chk_i("rr_d_ack_cycle", d_c, 2);
      chk_i("rr_i_ack_cycle", i_c, 4);
      idle_inputs();

      foreach (vecs[k]) run_vec(vecs[k]);

      // reset while a load is outstanding
      do_reset();
      @(negedge clk);
      bus.d_re   = 1'b1;
      bus.d_addr = 32'h700;
      @(negedge clk);
      chk_b("mid_busy_req", bus.mem_req, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk_b("mid_rst_req", bus.mem_req, 1'b0);
      chk_b("mid_rst_d_ack", bus.d_ack, 1'b0);
      chk_b("mid_rst_stall", bus.stall, 1'b0);
      chk_b("mid_rst_bus_err", bus.bus_err, 1'b0);
      chk_w("mid_rst_addr", bus.mem_addr, 32'h0);
      @(negedge clk);
      bus.d_re = 1'b0;
      rst = 1'b1;
      run_vec('{1'b0, 0, 32'h104, 32'h0, 4'h0, 0, 32'h0BADF00D,
                2, 1, 1'b0, 4'hF, 1'b0, 32'h0BADF00D, 1'b0});

      // randomized traffic
      do_reset();
      own = 0; ack_at = -1; req_last = -1; done_c = -1;
      last_d = 1'b0; ih = 1'b0; dh = 1'b0; dw = 1'b0;
      ia = '0; da = '0; dwd = '0; dbe = '0;
      t_we = 1'b0; t_addr = '0; t_wdata = '0; t_rd = '0; t_be = '0;
      e_i_ack = 1'b0; e_d_ack = 1'b0; e_i_err = 1'b0; e_d_err = 1'b0;
      e_req = 1'b0; e_berr = 1'b0; e_i_rd = '0; e_d_rd = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         chk_b("r_i_ack", bus.i_ack, e_i_ack);
         chk_b("r_d_ack", bus.d_ack, e_d_ack);
         chk_b("r_i_err", bus.i_err, e_i_err);
         chk_b("r_d_err", bus.d_err, e_d_err);
         chk_w("r_i_rdata", bus.i_rdata, e_i_rd);
         chk_w("r_d_rdata", bus.d_rdata, e_d_rd);
         chk_b("r_mem_req", bus.mem_req, e_req);
         chk_b("r_bus_err", bus.bus_err, e_berr);
         if (e_req) begin
            chk_b("r_mem_we", bus.mem_we, t_we);
            chk_w("r_mem_addr", bus.mem_addr, t_addr);
            chk_be("r_mem_be", bus.mem_be, t_be);
            if (t_we) chk_w("r_mem_wdata", bus.mem_wdata, t_wdata);
         end
         if (!ih || e_i_ack) begin
            ih = ($urandom_range(0, 2) != 0);
            ia = $urandom;
            ia[1:0] = 2'b00;
         end
         if (!dh || e_d_ack) begin
            dh  = ($urandom_range(0, 2) != 0);
            dw  = ($urandom_range(0, 1) != 0);
            da  = $urandom;
            dwd = $urandom;
            dbe = 4'($urandom);
         end
         bus.i_req     = ih;
         bus.i_addr    = ia;
         bus.d_re      = dh & ~dw;
         bus.d_we      = dh & dw;
         bus.d_addr    = da;
         bus.d_wdata   = dwd;
         bus.d_be      = dbe;
         bus.mem_ack   = (cyc == ack_at);
         bus.mem_rdata = (cyc == ack_at) ? t_rd : $urandom;
         #1 chk_b("r_stall", bus.stall,
                  (ih & ~e_i_ack) | (dh & ~e_d_ack));

         n_i_ack = 1'b0; n_d_ack = 1'b0;
         n_i_err = 1'b0; n_d_err = 1'b0;
         n_req = 1'b0;
         if (own != 0) begin
            if (cyc + 1 == done_c) begin
               if (own == 1) begin
                  n_i_ack = 1'b1;
                  n_i_err = tmo;
                  if (!tmo) e_i_rd = t_rd;
               end else begin
                  n_d_ack = 1'b1;
                  n_d_err = tmo;
                  if (!tmo && !t_we) e_d_rd = t_rd;
               end
               if (tmo) e_berr = 1'b1;
               own = 0;
            end
            n_req = (cyc + 1 <= req_last);
         end else begin
            ie = ih & ~e_i_ack;
            de = dh & ~e_d_ack;
            if (ie || de) begin
               pk = de && (!ie || !last_d);
               last_d = pk;
               own = pk ? 2 : 1;
               t_we    = pk ? dw : 1'b0;
               t_addr  = pk ? da : ia;
               t_be    = (pk && dw) ? dbe : 4'hF;
               t_wdata = pk ? dwd : 32'h0;
               t_rd    = $urandom;
               tmo = ($urandom_range(0, 7) == 0);
               lat = $urandom_range(0, TO - 1);
               if (!tmo) begin
                  ack_at   = cyc + 1 + lat;
                  req_last = cyc + 1 + lat;
                  done_c   = cyc + 2 + lat;
               end else begin
                  ack_at   = -1;
                  req_last = cyc + TO;
                  done_c   = cyc + TO + 2;
               end
               n_req = 1'b1;
            end
         end
         e_i_ack = n_i_ack; e_d_ack = n_d_ack;
         e_i_err = n_i_err; e_d_err = n_d_err;
         e_req = n_req;
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
